avalon_mm_reg_master: RTL and testbench

Avalon-MM register initiator that turns single-word read/write commands into Avalon-MM master transactions towards register slaves such as the message-counter/debug register block. It sits between a debug command source (host bridge, test sequencer) and the register interconnect. It keeps one transaction outstanding, honours `waitrequest` and variable read latency, and returns exactly one response per command, including a timeout response if the slave never completes.

---
 rtl/avalon_mm_if.sv | 17 +
 rtl/avalon_mm_reg_master.sv | 92 +++++++++
 tb/tb_avalon_mm_reg_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_if.sv
// avalon_mm_if: Avalon-MM register bus between one initiator and one slave
// Signals: address/read/write/writedata from the master,
// readdata/readdatavalid/waitrequest from the slave.
interface avalon_mm_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    modport master (output address, read, write, writedata, input readdata, readdatavalid, waitrequest);
    modport slave (input address, read, write, writedata, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/avalon_mm_reg_master.sv
// avalon_mm_reg_master: single-outstanding Avalon-MM register initiator with timeout
// Ports: cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_writedata accept one command,
// rsp_valid/rsp_write/rsp_timeout/rsp_readdata return its one-cycle response,
// timeout_cnt is a saturating timeout tally, reg_mm is the Avalon-MM master side.
module avalon_mm_reg_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_writedata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic                  rsp_timeout,
    output logic [DATA_WIDTH-1:0] rsp_readdata,
    output logic [15:0]           timeout_cnt,
    avalon_mm_if.master           reg_mm
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, RESP} state_t;
    state_t        state;
    logic          wr;
    logic [TW-1:0] tcnt;
    logic          done;
    logic          expire;
    // A write completes when accepted; a read only when its data beat arrives.
    assign done   = (state == REQ) ? (!reg_mm.waitrequest && wr) : (state == WAIT_DATA && reg_mm.readdatavalid);
    assign expire = (TIMEOUT_CYCLES != 0) && (tcnt == LAST);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cmd_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_timeout      <= 1'b0;
            rsp_readdata     <= '0;
            timeout_cnt      <= '0;
            wr               <= 1'b0;
            tcnt             <= '0;
            reg_mm.address   <= '0;
            reg_mm.read      <= 1'b0;
            reg_mm.write     <= 1'b0;
            reg_mm.writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= !(cmd_valid && cmd_ready);
                    if (cmd_valid && cmd_ready) begin
                        wr               <= cmd_write;
                        tcnt             <= '0;
                        reg_mm.address   <= cmd_address;
                        reg_mm.writedata <= cmd_writedata;
                        reg_mm.read      <= !cmd_write;
                        reg_mm.write     <= cmd_write;
                        state            <= REQ;
                    end
                end
                REQ, WAIT_DATA: begin
                    tcnt <= tcnt + TW'(1);
                    // Completion beats expiry when both land in the same cycle.
                    if (done || expire) begin
                        reg_mm.read  <= 1'b0;
                        reg_mm.write <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= wr;
                        rsp_timeout  <= !done;
                        rsp_readdata <= (done && !wr) ? reg_mm.readdata : '0;
                        timeout_cnt  <= (!done && timeout_cnt != 16'hFFFF) ? timeout_cnt + 16'd1 : timeout_cnt;
                        state        <= RESP;
                    end else if (state == REQ && !reg_mm.waitrequest) begin
                        reg_mm.read <= 1'b0;
                        state       <= WAIT_DATA;
                    end
                end
                RESP: begin
                    rsp_valid    <= 1'b0;
                    rsp_write    <= 1'b0;
                    rsp_timeout  <= 1'b0;
                    rsp_readdata <= '0;
                    cmd_ready    <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_mm_reg_master.sv
// tb_avalon_mm_reg_master: randomized transaction bench with a cycle-offset reference model
module tb_avalon_mm_reg_master;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_address = '0;
    logic [31:0] cmd_writedata = '0;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_timeout;
    logic [31:0] rsp_readdata;
    logic [15:0] timeout_cnt;

    avalon_mm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    avalon_mm_reg_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
        .rsp_readdata(rsp_readdata), .timeout_cnt(timeout_cnt), .reg_mm(bus)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Current transaction plan: handshake cycle t0, pw waitrequest cycles,
    // read data pl cycles after acceptance.
    bit          active = 0;
    bit          pis_w = 0;
    int          t0 = 0, pw = 0, pl = 1, rdy_cyc = 0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0, prdata = '0;
    int          m_tcnt = 0;
    int          req_cnt = 0;
    int          last_rel = -1;
    logic [31:0] last_rdata = '0;
    bit          last_to = 0, last_wr = 0;

    // Offset from the handshake of the cycle in which the slave completes.
    function automatic int p_off();
        return pis_w ? pw + 1 : pw + 1 + pl;
    endfunction
    function automatic int p_end();
        return (p_off() > TO) ? TO : p_off();
    endfunction
    function automatic bit p_to();
        return p_off() > TO;
    endfunction

    initial forever begin
        int rel, rr, req_end;
        bit busy, req, rsp;
        @(negedge clk);
        if (rst) begin
            m_tcnt = 0;
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_read_write", {bus.read, bus.write}, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_timeout_cnt", timeout_cnt, 0);
        end else begin
            rel = cyc - t0;
            rr = p_end() + 1;
            req_end = (pw + 1 < TO) ? pw + 1 : TO;
            busy = active && rel >= 1 && rel <= rr;
            req = active && rel >= 1 && rel <= req_end;
            rsp = active && rel == rr;
            if (rsp && p_to() && m_tcnt < 16'hFFFF) m_tcnt++;
            chk("cmd_ready", cmd_ready, !busy && cyc >= rdy_cyc);
            chk("read", bus.read, req && !pis_w);
            chk("write", bus.write, req && pis_w);
            if (req) begin
                chk("address", bus.address, paddr);
                if (pis_w) chk("writedata", bus.writedata, pwdata);
            end
            chk("rsp_valid", rsp_valid, rsp);
            if (rsp) begin
                chk("rsp_write", rsp_write, pis_w);
                chk("rsp_timeout", rsp_timeout, p_to());
                chk("rsp_readdata", rsp_readdata, (pis_w || p_to()) ? 32'h0 : prdata);
            end
            chk("timeout_cnt", timeout_cnt, m_tcnt);
            if (rsp_valid) begin
                last_rel = rel;
                last_rdata = rsp_readdata;
                last_to = rsp_timeout;
                last_wr = rsp_write;
            end
            if (bus.read || bus.write) req_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            cmd_valid = 0;
            bus.waitrequest = 1'($urandom);
            bus.readdatavalid = 1'($urandom);
            bus.readdata = $urandom;
        end
    endtask

    task automatic run_cmd(input bit w, input logic [15:0] a, input logic [31:0] d,
                           input int wt, input int lat, input logic [31:0] rd, input int abort_at);
        int waited = 0;
        int rr;
        while (!cmd_ready && waited < 40) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = w; cmd_address = a; cmd_writedata = d;
        pis_w = w; paddr = a; pwdata = d; pw = wt; pl = lat; prdata = rd;
        t0 = cyc; active = 1; req_cnt = 0;
        rr = p_end() + 1;
        for (int r = 1; r <= rr; r++) begin
            @(negedge clk); #1;
            cmd_valid = 0;
            cmd_write = 1'($urandom); cmd_address = 16'($urandom); cmd_writedata = $urandom;
            bus.waitrequest = (r <= wt);
            if (!w && r == wt + 1 + lat) begin
                bus.readdatavalid = 1;
                bus.readdata = rd;
            end else begin
                bus.readdatavalid = (w || r <= wt + 1 || r > p_end()) ? 1'($urandom) : 1'b0;
                bus.readdata = $urandom;
            end
            if (r == abort_at) begin
                bus.readdatavalid = 0;
                rst = 1;
                #1;
                chk("abort_read_write", {bus.read, bus.write}, 0);
                chk("abort_rsp_valid", rsp_valid, 0);
                return;
            end
        end
    endtask

    initial begin
        bus.waitrequest = 0; bus.readdatavalid = 0; bus.readdata = '0;
        repeat (3) @(negedge clk);
        #1; rst = 0; rdy_cyc = cyc + 1;
        run_cmd(1, 16'h402, 32'hDEADBEEF, 0, 1, 0, 0);
        chk("wr_rsp_rel", last_rel, 2);
        chk("wr_rsp_write", last_wr, 1);
        chk("wr_rsp_timeout", last_to, 0);
        chk("wr_req_cycles", req_cnt, 1);
        run_cmd(0, 16'h400, 0, 0, 1, 32'h7, 0);
        chk("rd_rsp_rel", last_rel, 3);
        chk("rd_rsp_data", last_rdata, 32'h7);
        @(negedge clk); #1;
        chk("rd_ready_t4", cmd_ready, 1);
        run_cmd(0, 16'h400, 0, 3, 1, 32'h12345678, 0);
        chk("rdws_rsp_rel", last_rel, 6);
        chk("rdws_req_cycles", req_cnt, 4);
        chk("rdws_rsp_data", last_rdata, 32'h12345678);
        run_cmd(0, 16'h404, 0, 0, 8, 32'hBAD0BAD0, 0);
        chk("to_rsp_rel", last_rel, 9);
        chk("to_rsp_timeout", last_to, 1);
        chk("to_rsp_data", last_rdata, 0);
        chk("to_count", timeout_cnt, 1);
        @(negedge clk); #1;
        bus.readdatavalid = 1; bus.readdata = 32'hBAD0BAD0;
        @(negedge clk); #1;
        bus.readdatavalid = 0;
        chk("late_beat_ignored", rsp_valid, 0);
        run_cmd(0, 16'h408, 0, 0, 7, 32'hA5A50001, 0);
        chk("exp_rsp_rel", last_rel, 9);
        chk("exp_rsp_timeout", last_to, 0);
        chk("exp_rsp_data", last_rdata, 32'hA5A50001);
        chk("exp_count_kept", timeout_cnt, 1);
        last_rel = -1;
        run_cmd(0, 16'h40C, 0, 0, 8, 32'h0, 3);
        repeat (2) begin
            @(negedge clk); #1;
        end
        rst = 0; active = 0; rdy_cyc = cyc + 1;
        idle(12);
        chk("abort_no_rsp", last_rel, -1);
        chk("abort_count_cleared", timeout_cnt, 0);
        run_cmd(1, 16'h10, 32'hCAFEF00D, 1, 1, 0, 0);
        chk("post_abort_rel", last_rel, 3);
        chk("post_abort_to", last_to, 0);
        repeat (150) begin
            int wt, lat;
            wt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 3);
            run_cmd(1'($urandom), 16'($urandom), $urandom, wt, lat, $urandom, 0);
            idle($urandom_range(0, 2));
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end
endmodule
